sh7034_ibus_arb: RTL and testbench
==================================

SH7034_IBUS_ARB -- requirements
Module: sh7034_ibus_arb

Interface
REQ-001 Parameter TO_CYCLES, default 255: slave wait-state limit in CE_R cycles before forced completion.
REQ-002 CLK  in  1  system clock; all state changes on posedge CLK.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 CE_R / CE_F  in  1 each  rising/falling phase enables; all arbiter state advances on CE_R only.
REQ-005 RES_N  in  1  synchronous soft reset, sampled on CE_R.
REQ-006 CPU_A[27:0], CPU_DI[31:0], CPU_BA[3:0], CPU_WE, CPU_REQ, CPU_LOCK  in: CPU master request.
REQ-007 CPU_DO[31:0], CPU_BUSY  out: CPU master response.
REQ-008 DMA_A[27:0], DMA_DI[31:0], DMA_BA[3:0], DMA_WE, DMA_REQ, DMA_LOCK  in: DMAC master request.
REQ-009 DMA_DO[31:0], DMA_BUSY  out: DMAC master response.
REQ-010 IBUS_A[27:0], IBUS_DO[31:0], IBUS_BA[3:0], IBUS_WE, IBUS_REQ  out: shared peripheral bus.
REQ-011 IBUS_DI[31:0], IBUS_BUSY, IBUS_ACT  in: OR-combined peripheral read data, wait, address-decoded.
REQ-012 BUS_ERR  out  1  one-CE_R-cycle pulse on timeout or unmapped access.

Function
REQ-013 States: IDLE, GNT_CPU, GNT_DMA.
REQ-014 IDLE: IBUS_REQ=0; any asserted CPU_REQ/DMA_REQ sees its BUSY=1.
REQ-015 IDLE on CE_R: only one REQ -> grant it; both -> DMA wins (fixed priority).
REQ-016 GNT_x: IBUS_A/DO/BA/WE driven combinationally from granted master, IBUS_REQ = granted REQ; ungranted master's BUSY=1 while its REQ=1.
REQ-017 Granted master's BUSY = IBUS_BUSY; DO = IBUS_DI when IBUS_ACT=1 and read; otherwise DO = 0.
REQ-018 Completion: CE_R with grant, REQ=1, IBUS_BUSY=0; the master sees BUSY=0 in that cycle.
REQ-019 After completion: granted LOCK=1 -> hold the same grant; else if other master REQ=1 -> switch directly to its grant; else -> IDLE.
REQ-020 Granted master drops REQ with no completion -> IDLE at next CE_R, no error.
REQ-021 Unmapped: IBUS_ACT=0 while granted -> complete that cycle (BUSY=0, DO=0), BUS_ERR pulse.
REQ-022 Wait counter, 8 bit min, cleared at grant and at each completion, increments per CE_R with IBUS_BUSY=1.
REQ-023 Counter == TO_CYCLES -> forced completion: master BUSY=0, DO=0, BUS_ERR pulse, counter cleared.
REQ-024 LOCK is ignored in IDLE; LOCK starvation is bounded only by the master releasing LOCK.
REQ-025 Ungranted master REQ and LOCK changes have no effect until its grant.

Reset
REQ-026 RST_N=0 asynchronously -> IDLE, counter 0, BUS_ERR=0; all master DO outputs 0; IBUS_REQ=0; BUSY outputs follow REQ-014.
REQ-027 RES_N=0 on CE_R -> same state as REQ-026, including mid-transfer; the aborted master sees BUSY=1 until re-granted.

Configuration
REQ-028 Macro SH7034_IBUS_RR_EN defined: round-robin on simultaneous requests; a last-grant bit (reset 0=CPU) gives priority to the master not served last; without it, fixed DMA priority per REQ-015.

Structure
REQ-029 Shared package SH7034_PKG holds the state enum IBUSArbState_t and the default TO_CYCLES constant.
REQ-030 One sub-module sh7034_ibus_mux: pure combinational master-to-IBUS select. FSM, counter and error logic stay in the top.

Verification
REQ-031 CPU read at 5FFFF90, slave BUSY 2 cycles, IBUS_DI=12340000 -> grant 1 CE_R after REQ, CPU_DO=12340000, CPU_BUSY low on 3rd granted cycle.
REQ-032 CPU_REQ and DMA_REQ both rise in the same cycle -> DMA granted first; CPU granted directly after with no IDLE cycle. With SH7034_IBUS_RR_EN, second collision -> CPU first.
REQ-033 CPU_LOCK=1 read then write to 5FFFF98 with DMA_REQ pending -> both CPU accesses complete before the DMA grant.
REQ-034 DMA write to 4000000 with IBUS_ACT=0 -> DMA_BUSY=0 same cycle, BUS_ERR 1-cycle pulse, state IDLE.
REQ-035 TO_CYCLES=4, IBUS_BUSY stuck high -> forced completion on 4th wait cycle, DO=0, BUS_ERR pulse.
REQ-036 RES_N low during GNT_DMA wait -> IDLE next CE_R, IBUS_REQ=0, counter 0.

Source files
------------

// File: rtl/sh7034_ibus_arb_pkg.sv
// Shared types and defaults for the SH7034 internal-bus arbiter.
package SH7034_PKG;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2
  } IBUSArbState_t;

  localparam int IBUS_TO_CYCLES_DEF = 255;

endpackage

// File: rtl/sh7034_ibus_mux.sv
// Combinational master-to-IBUS request select; IBUS_REQ is low unless a grant is active.
module sh7034_ibus_mux (
  input  logic        gnt_en,
  input  logic        sel_dma,
  input  logic [27:0] cpu_a,
  input  logic [31:0] cpu_di,
  input  logic [3:0]  cpu_ba,
  input  logic        cpu_we,
  input  logic        cpu_req,
  input  logic [27:0] dma_a,
  input  logic [31:0] dma_di,
  input  logic [3:0]  dma_ba,
  input  logic        dma_we,
  input  logic        dma_req,
  output logic [27:0] ibus_a,
  output logic [31:0] ibus_do,
  output logic [3:0]  ibus_ba,
  output logic        ibus_we,
  output logic        ibus_req
);

  always_comb begin
    ibus_a   = sel_dma ? dma_a  : cpu_a;
    ibus_do  = sel_dma ? dma_di : cpu_di;
    ibus_ba  = sel_dma ? dma_ba : cpu_ba;
    ibus_we  = sel_dma ? dma_we : cpu_we;
    ibus_req = gnt_en & (sel_dma ? dma_req : cpu_req);
  end

endmodule

// File: rtl/sh7034_ibus_arb.sv
// SH7034 CPU/DMAC arbiter for the internal peripheral bus with wait timeout and unmapped-access error.
// Optional macro SH7034_IBUS_RR_EN selects round-robin on simultaneous requests (default: DMA priority).
module sh7034_ibus_arb
  import SH7034_PKG::*;
#(
  parameter int TO_CYCLES = IBUS_TO_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic [27:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [3:0]  CPU_BA,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  input  logic        CPU_LOCK,
  output logic [31:0] CPU_DO,
  output logic        CPU_BUSY,
  input  logic [27:0] DMA_A,
  input  logic [31:0] DMA_DI,
  input  logic [3:0]  DMA_BA,
  input  logic        DMA_WE,
  input  logic        DMA_REQ,
  input  logic        DMA_LOCK,
  output logic [31:0] DMA_DO,
  output logic        DMA_BUSY,
  output logic [27:0] IBUS_A,
  output logic [31:0] IBUS_DO,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic [31:0] IBUS_DI,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT,
  output logic        BUS_ERR
);

  localparam int CW = ($clog2(TO_CYCLES + 1) > 8) ? $clog2(TO_CYCLES + 1) : 8;

  IBUSArbState_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          bus_err_reg, bus_err_next;
  logic          gnt_en, sel_dma, g_req, g_lock, g_we, o_req;
  logic          tmo, done, g_busy, dma_first;
  logic [31:0]   g_do;
  logic          unused_ce_f;

  assign unused_ce_f = CE_F;

`ifdef SH7034_IBUS_RR_EN
  // 0 = CPU was granted last from IDLE, so the DMA is preferred next.
  logic lg_reg, lg_next;
  assign dma_first = ~lg_reg;
`else
  assign dma_first = 1'b1;
`endif

  always_comb begin
    gnt_en  = (state_reg != IDLE);
    sel_dma = (state_reg == GNT_DMA);
    g_req   = sel_dma ? DMA_REQ  : CPU_REQ;
    g_lock  = sel_dma ? DMA_LOCK : CPU_LOCK;
    g_we    = sel_dma ? DMA_WE   : CPU_WE;
    o_req   = sel_dma ? CPU_REQ  : DMA_REQ;
    tmo     = (cnt_reg == CW'(TO_CYCLES));
    // Unmapped and timed-out accesses terminate the transfer with zero data.
    done    = gnt_en & g_req & (~IBUS_ACT | ~IBUS_BUSY | tmo);
    g_busy  = IBUS_ACT & IBUS_BUSY & ~tmo;
    g_do    = (IBUS_ACT & ~g_we & ~tmo) ? IBUS_DI : 32'h0;

    CPU_BUSY = (state_reg == GNT_CPU) ? g_busy : CPU_REQ;
    DMA_BUSY = (state_reg == GNT_DMA) ? g_busy : DMA_REQ;
    CPU_DO   = (state_reg == GNT_CPU) ? g_do : 32'h0;
    DMA_DO   = (state_reg == GNT_DMA) ? g_do : 32'h0;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bus_err_next = 1'b0;
`ifdef SH7034_IBUS_RR_EN
    lg_next      = lg_reg;
`endif
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (DMA_REQ && (!CPU_REQ || dma_first)) begin
          state_next = GNT_DMA;
`ifdef SH7034_IBUS_RR_EN
          lg_next    = 1'b1;
`endif
        end else if (CPU_REQ) begin
          state_next = GNT_CPU;
`ifdef SH7034_IBUS_RR_EN
          lg_next    = 1'b0;
`endif
        end
      end
      GNT_CPU, GNT_DMA: begin
        if (!g_req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (done) begin
          cnt_next     = '0;
          bus_err_next = ~IBUS_ACT | tmo;
          if (g_lock)
            state_next = state_reg;
          else if (o_req)
            state_next = sel_dma ? GNT_CPU : GNT_DMA;
          else
            state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bus_err_reg <= 1'b0;
`ifdef SH7034_IBUS_RR_EN
      lg_reg      <= 1'b0;
`endif
    end else if (CE_R) begin
      if (!RES_N) begin
        state_reg   <= IDLE;
        cnt_reg     <= '0;
        bus_err_reg <= 1'b0;
`ifdef SH7034_IBUS_RR_EN
        lg_reg      <= 1'b0;
`endif
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        bus_err_reg <= bus_err_next;
`ifdef SH7034_IBUS_RR_EN
        lg_reg      <= lg_next;
`endif
      end
    end
  end

  assign BUS_ERR = bus_err_reg;

  sh7034_ibus_mux u_mux (
    .gnt_en   (gnt_en),
    .sel_dma  (sel_dma),
    .cpu_a    (CPU_A),
    .cpu_di   (CPU_DI),
    .cpu_ba   (CPU_BA),
    .cpu_we   (CPU_WE),
    .cpu_req  (CPU_REQ),
    .dma_a    (DMA_A),
    .dma_di   (DMA_DI),
    .dma_ba   (DMA_BA),
    .dma_we   (DMA_WE),
    .dma_req  (DMA_REQ),
    .ibus_a   (IBUS_A),
    .ibus_do  (IBUS_DO),
    .ibus_ba  (IBUS_BA),
    .ibus_we  (IBUS_WE),
    .ibus_req (IBUS_REQ)
  );

endmodule

// File: tb/tb_sh7034_ibus_arb.sv
// Scoreboard bench for sh7034_ibus_arb: directed master transfers against a simple wait-state slave.
module tb_sh7034_ibus_arb;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        CE_R = 1'b1;
  logic        CE_F = 1'b0;
  logic        RES_N = 1'b1;
  logic [27:0] CPU_A = '0, DMA_A = '0;
  logic [31:0] CPU_DI = '0, DMA_DI = '0;
  logic [3:0]  CPU_BA = '0, DMA_BA = '0;
  logic        CPU_WE = 1'b0, CPU_REQ = 1'b0, CPU_LOCK = 1'b0;
  logic        DMA_WE = 1'b0, DMA_REQ = 1'b0, DMA_LOCK = 1'b0;
  logic [31:0] CPU_DO, DMA_DO;
  logic        CPU_BUSY, DMA_BUSY;
  logic [27:0] IBUS_A;
  logic [31:0] IBUS_DO, IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT, BUS_ERR;

  always #5 CLK = ~CLK;

  sh7034_ibus_arb #(.TO_CYCLES(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_BA(CPU_BA), .CPU_WE(CPU_WE),
    .CPU_REQ(CPU_REQ), .CPU_LOCK(CPU_LOCK), .CPU_DO(CPU_DO), .CPU_BUSY(CPU_BUSY),
    .DMA_A(DMA_A), .DMA_DI(DMA_DI), .DMA_BA(DMA_BA), .DMA_WE(DMA_WE),
    .DMA_REQ(DMA_REQ), .DMA_LOCK(DMA_LOCK), .DMA_DO(DMA_DO), .DMA_BUSY(DMA_BUSY),
    .IBUS_A(IBUS_A), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE),
    .IBUS_REQ(IBUS_REQ), .IBUS_DI(IBUS_DI), .IBUS_BUSY(IBUS_BUSY),
    .IBUS_ACT(IBUS_ACT), .BUS_ERR(BUS_ERR)
  );

  // Slave: region 0x5xxxxxx is mapped; inserts 'waits' busy cycles, or stays busy while 'stuck'.
  int          waits = 0;
  bit          stuck = 1'b0;
  logic [31:0] rdata = '0;
  int          wcnt = 0;
  assign IBUS_ACT  = IBUS_REQ && (IBUS_A[27:24] == 4'h5);
  assign IBUS_BUSY = IBUS_ACT && (stuck || (wcnt < waits));
  assign IBUS_DI   = IBUS_ACT ? rdata : 32'h0;
  always @(posedge CLK) begin
    if (IBUS_REQ && IBUS_BUSY) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          m;
    logic [31:0] d;
    bit          e;
    string       tag;
  } exp_t;
  exp_t q[$];

  task automatic push(input bit m, input logic [31:0] d, input bit e, input string tag);
    exp_t x;
    x.m = m; x.d = d; x.e = e; x.tag = tag;
    q.push_back(x);
  endtask

  task automatic sb_pop(input bit m, input logic [31:0] d, output bit e);
    exp_t x;
    e = 1'b0;
    if (q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL sb unexpected completion: master=%0d do=%h, none expected", m, d);
    end else begin
      x = q.pop_front();
      chk({x.tag, " master"}, 64'(m), 64'(x.m));
      chk({x.tag, " do"}, 64'(d), 64'(x.d));
      e = x.e;
      $display("completion %s: master=%0d do=%h err_exp=%0d", x.tag, m, d, x.e);
    end
  endtask

  // Monitor: a completion is REQ=1 with BUSY=0; BUS_ERR is expected one cycle after an error completion.
  bit err_due = 1'b0;
  always @(negedge CLK) begin : monitor
    bit nd, ec, ed;
    nd = 1'b0; ec = 1'b0; ed = 1'b0;
    if (err_due || BUS_ERR) chk("bus_err pulse", 64'(BUS_ERR), 64'(err_due));
    if (RST_N && CE_R) begin
      if (CPU_REQ && !CPU_BUSY) sb_pop(1'b0, CPU_DO, ec);
      if (DMA_REQ && !DMA_BUSY) sb_pop(1'b1, DMA_DO, ed);
      nd = ec | ed;
    end
    err_due = nd;
  end

  task automatic xfer(input bit m, input logic [27:0] a, input bit we, input logic [31:0] d,
                      input bit lock, output int n);
    bit fin;
    n = 0;
    fin = 1'b0;
    if (m) begin
      DMA_A = a; DMA_WE = we; DMA_DI = d; DMA_BA = 4'hF; DMA_LOCK = lock; DMA_REQ = 1'b1;
    end else begin
      CPU_A = a; CPU_WE = we; CPU_DI = d; CPU_BA = 4'hF; CPU_LOCK = lock; CPU_REQ = 1'b1;
    end
    while (!fin && n < 40) begin
      @(negedge CLK);
      n++;
      if (m ? !DMA_BUSY : !CPU_BUSY) fin = 1'b1;
    end
    @(posedge CLK);
    #1;
    if (!fin) begin
      checks++;
      fails++;
      $display("FAIL xfer timeout: master=%0d addr=%h still busy after %0d cycles", m, a, n);
    end
    if (m) begin DMA_REQ = 1'b0; DMA_LOCK = 1'b0; end
    else   begin CPU_REQ = 1'b0; CPU_LOCK = 1'b0; end
  endtask

  initial begin : global_timeout
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n, n1, n2, n3;
    #2 RST_N = 1'b0;
    CPU_REQ = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset ibus_req", 64'(IBUS_REQ), 64'd0);
    chk("reset cpu_busy", 64'(CPU_BUSY), 64'd1);
    chk("reset dma_busy", 64'(DMA_BUSY), 64'd0);
    chk("reset bus_err", 64'(BUS_ERR), 64'd0);
    chk("reset cpu_do", 64'(CPU_DO), 64'd0);
    chk("reset dma_do", 64'(DMA_DO), 64'd0);
    @(posedge CLK); #1;
    CPU_REQ = 1'b0;
    RST_N = 1'b1;
    repeat (2) @(posedge CLK); #1;

    // CPU read, two slave wait cycles.
    waits = 2; rdata = 32'h12340000;
    push(1'b0, 32'h12340000, 1'b0, "t1 cpu read");
    fork
      xfer(1'b0, 28'h5FFFF90, 1'b0, 32'h0, 1'b0, n);
      begin
        @(negedge CLK);
        chk("t1 idle ibus_req", 64'(IBUS_REQ), 64'd0);
        @(negedge CLK);
        chk("t1 grant ibus_req", 64'(IBUS_REQ), 64'd1);
        chk("t1 grant ibus_a", 64'(IBUS_A), 64'h5FFFF90);
      end
    join
    chk("t1 cpu cycles to done", 64'(n), 64'd4);

    // Two collisions back to back; the second is resolved by round-robin when enabled.
    waits = 1; rdata = 32'hA5A55A5A;
    push(1'b1, 32'h0, 1'b0, "t2a dma write");
    push(1'b0, 32'hA5A55A5A, 1'b0, "t2a cpu read");
    fork
      xfer(1'b0, 28'h5FFFF90, 1'b0, 32'h0, 1'b0, n1);
      xfer(1'b1, 28'h5FFFF98, 1'b1, 32'hCAFEF00D, 1'b0, n2);
    join
    chk("t2a dma cycles", 64'(n2), 64'd3);
    chk("t2a cpu cycles no idle gap", 64'(n1), 64'd5);
`ifdef SH7034_IBUS_RR_EN
    push(1'b0, 32'hA5A55A5A, 1'b0, "t2b cpu read");
    push(1'b1, 32'h0, 1'b0, "t2b dma write");
`else
    push(1'b1, 32'h0, 1'b0, "t2b dma write");
    push(1'b0, 32'hA5A55A5A, 1'b0, "t2b cpu read");
`endif
    fork
      xfer(1'b0, 28'h5FFFF90, 1'b0, 32'h0, 1'b0, n1);
      xfer(1'b1, 28'h5FFFF98, 1'b1, 32'h0BADBEEF, 1'b0, n2);
    join
`ifdef SH7034_IBUS_RR_EN
    chk("t2b cpu cycles", 64'(n1), 64'd3);
    chk("t2b dma cycles", 64'(n2), 64'd5);
`else
    chk("t2b dma cycles", 64'(n2), 64'd3);
    chk("t2b cpu cycles", 64'(n1), 64'd5);
`endif

    // Locked CPU read-then-write keeps the bus while the DMA waits.
    waits = 1; rdata = 32'h00C0FFEE;
    push(1'b0, 32'h00C0FFEE, 1'b0, "t3 cpu locked read");
    push(1'b0, 32'h0, 1'b0, "t3 cpu write");
    push(1'b1, 32'h0, 1'b0, "t3 dma write");
    fork
      begin
        xfer(1'b0, 28'h5FFFF98, 1'b0, 32'h0, 1'b1, n1);
        xfer(1'b0, 28'h5FFFF98, 1'b1, 32'h000055AA, 1'b0, n2);
      end
      begin
        @(posedge CLK); #1;
        xfer(1'b1, 28'h5FFFF9C, 1'b1, 32'h11112222, 1'b0, n3);
      end
    join
    chk("t3 cpu read cycles", 64'(n1), 64'd3);
    chk("t3 cpu write cycles", 64'(n2), 64'd2);
    chk("t3 dma cycles", 64'(n3), 64'd6);

    // Unmapped DMA write.
    waits = 0;
    push(1'b1, 32'h0, 1'b1, "t4 dma unmapped");
    xfer(1'b1, 28'h4000000, 1'b1, 32'hDEAD0000, 1'b0, n);
    chk("t4 dma cycles", 64'(n), 64'd2);
    @(negedge CLK);
    chk("t4 ibus_req after", 64'(IBUS_REQ), 64'd0);
    @(posedge CLK); #1;

    // Slave stuck busy: forced completion after four counted wait cycles.
    stuck = 1'b1; rdata = 32'hFFFF1111;
    push(1'b0, 32'h0, 1'b1, "t5 cpu timeout");
    xfer(1'b0, 28'h5FFFF90, 1'b0, 32'h0, 1'b0, n);
    chk("t5 cpu cycles", 64'(n), 64'd6);
    stuck = 1'b0;
    repeat (2) @(posedge CLK); #1;

    // Soft reset in the middle of a DMA wait, then the DMA is re-granted.
    stuck = 1'b1;
    DMA_A = 28'h5FFFF98; DMA_WE = 1'b1; DMA_DI = 32'h77778888; DMA_BA = 4'hF; DMA_REQ = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RES_N = 1'b0;
    @(negedge CLK);
    chk("t6 ibus_req before soft reset", 64'(IBUS_REQ), 64'd1);
    @(negedge CLK);
    chk("t6 ibus_req after soft reset", 64'(IBUS_REQ), 64'd0);
    chk("t6 dma_busy after soft reset", 64'(DMA_BUSY), 64'd1);
    @(posedge CLK); #1;
    RES_N = 1'b1; stuck = 1'b0; waits = 0;
    push(1'b1, 32'h0, 1'b0, "t6 dma regrant");
    xfer(1'b1, 28'h5FFFF98, 1'b1, 32'h77778888, 1'b0, n);
    chk("t6 dma regrant cycles", 64'(n), 64'd2);

    repeat (3) @(negedge CLK);
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
